// File: rtl/rpn_stack_engine.sv
// rpn_stack_engine: command-driven RPN evaluator that sequences push/pop strobes on an external LIFO.
// Latency: accept to RES_STB is 1 cycle for PUSH, 3 for DUP and 5 for binary ops; DROP and REJECT finish in 1 cycle.
// Backpressure: CMD_RDY is high only in IDLE, and commands offered while busy are dropped. Define RPN_MUL_EN to enable opcode 8 (MUL).
module rpn_stack_engine #(
  parameter  int DEPTH = 16,
  parameter  int DW    = 32,
  localparam int DCW   = $clog2(DEPTH + 1)
) (
  input  logic           CLK,
  input  logic           RST,
  input  logic           CMD_STB,
  input  logic [3:0]     CMD_OP,
  input  logic [DW-1:0]  CMD_DAT,
  output logic           CMD_RDY,
  output logic           RES_STB,
  output logic [DW-1:0]  RES_DAT,
  output logic           ERR,
  output logic [DCW-1:0] DEPTH_O,
  output logic           STK_PUSH_STB,
  output logic [DW-1:0]  STK_PUSH_DAT,
  output logic           STK_POP_STB,
  input  logic [DW-1:0]  STK_POP_DAT,
  input  logic           STK_POP_ACK
);

  localparam logic [3:0] OP_PUSH = 4'd0;
  localparam logic [3:0] OP_ADD  = 4'd1;
  localparam logic [3:0] OP_SUB  = 4'd2;
  localparam logic [3:0] OP_AND  = 4'd3;
  localparam logic [3:0] OP_OR   = 4'd4;
  localparam logic [3:0] OP_XOR  = 4'd5;
  localparam logic [3:0] OP_DUP  = 4'd6;
  localparam logic [3:0] OP_DROP = 4'd7;
  localparam logic [3:0] OP_MUL  = 4'd8;

  localparam logic [DCW-1:0] D_FULL = DCW'(DEPTH);
  localparam logic [DCW-1:0] D_ONE  = DCW'(1);
  localparam logic [DCW-1:0] D_TWO  = DCW'(2);

  typedef enum logic [2:0] {
    S_IDLE, S_SETTLE1, S_RD_B, S_SETTLE2, S_RD_A, S_EXEC, S_REJECT
  } state_t;

  state_t         state_q;
  logic [3:0]     op_q;
  logic [DW-1:0]  b_q;
  logic [DCW-1:0] depth_q;
  logic           err_q;
  logic           res_stb_q;
  logic [DW-1:0]  res_dat_q;
  logic           push_stb_q;
  logic [DW-1:0]  push_dat_q;
  logic           pop_stb_q;

  logic           cmd_ok;
  logic [DW-1:0]  alu_d;

  assign CMD_RDY      = (state_q == S_IDLE);
  assign RES_STB      = res_stb_q;
  assign RES_DAT      = res_dat_q;
  assign ERR          = err_q;
  assign DEPTH_O      = depth_q;
  assign STK_PUSH_STB = push_stb_q;
  assign STK_PUSH_DAT = push_dat_q;
  assign STK_POP_STB  = pop_stb_q;

  // Admission check on the offered opcode, using the local depth count and the stack's empty flag
  always_comb begin
    cmd_ok = 1'b0;
    case (CMD_OP)
      OP_PUSH: cmd_ok = (depth_q < D_FULL);
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR:
               cmd_ok = (depth_q >= D_TWO) && !STK_POP_ACK;
`ifdef RPN_MUL_EN
      OP_MUL:  cmd_ok = (depth_q >= D_TWO) && !STK_POP_ACK;
`endif
      OP_DUP:  cmd_ok = (depth_q >= D_ONE) && !STK_POP_ACK && (depth_q < D_FULL);
      OP_DROP: cmd_ok = (depth_q >= D_ONE) && !STK_POP_ACK;
      default: cmd_ok = 1'b0;
    endcase
  end

  // Binary-op result: a is the second entry, read live in RD_A; b was latched in RD_B
  always_comb begin
    alu_d = b_q;
    case (op_q)
      OP_ADD:  alu_d = STK_POP_DAT + b_q;
      OP_SUB:  alu_d = STK_POP_DAT - b_q;
      OP_AND:  alu_d = STK_POP_DAT & b_q;
      OP_OR:   alu_d = STK_POP_DAT | b_q;
      OP_XOR:  alu_d = STK_POP_DAT ^ b_q;
`ifdef RPN_MUL_EN
      OP_MUL:  alu_d = STK_POP_DAT * b_q;
`endif
      default: alu_d = b_q;
    endcase
  end

  // Command sequencer; strobes are registered on entry to the state that owns them and are one cycle wide
  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q    <= S_IDLE;
      op_q       <= OP_PUSH;
      b_q        <= '0;
      depth_q    <= '0;
      err_q      <= 1'b0;
      res_stb_q  <= 1'b0;
      res_dat_q  <= '0;
      push_stb_q <= 1'b0;
      push_dat_q <= '0;
      pop_stb_q  <= 1'b0;
    end else begin
      res_stb_q  <= 1'b0;
      push_stb_q <= 1'b0;
      pop_stb_q  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (CMD_STB) begin
            op_q <= CMD_OP;
            if (!cmd_ok) begin
              state_q <= S_REJECT;
              err_q   <= 1'b1;
            end else if (CMD_OP == OP_PUSH) begin
              state_q    <= S_EXEC;
              push_stb_q <= 1'b1;
              push_dat_q <= CMD_DAT;
              res_stb_q  <= 1'b1;
              res_dat_q  <= CMD_DAT;
              depth_q    <= depth_q + D_ONE;
            end else if (CMD_OP == OP_DROP) begin
              state_q   <= S_EXEC;
              pop_stb_q <= 1'b1;
              depth_q   <= depth_q - D_ONE;
            end else begin
              state_q <= S_SETTLE1;
            end
          end
        end
        S_SETTLE1: begin
          state_q <= S_RD_B;
          // DUP only peeks at the top entry, so it pops nothing
          if (op_q != OP_DUP) begin
            pop_stb_q <= 1'b1;
            depth_q   <= depth_q - D_ONE;
          end
        end
        S_RD_B: begin
          b_q <= STK_POP_DAT;
          if (op_q == OP_DUP) begin
            state_q    <= S_EXEC;
            push_stb_q <= 1'b1;
            push_dat_q <= STK_POP_DAT;
            res_stb_q  <= 1'b1;
            res_dat_q  <= STK_POP_DAT;
            depth_q    <= depth_q + D_ONE;
          end else begin
            state_q <= S_SETTLE2;
          end
        end
        S_SETTLE2: begin
          state_q   <= S_RD_A;
          pop_stb_q <= 1'b1;
          depth_q   <= depth_q - D_ONE;
        end
        S_RD_A: begin
          state_q    <= S_EXEC;
          push_stb_q <= 1'b1;
          push_dat_q <= alu_d;
          res_stb_q  <= 1'b1;
          res_dat_q  <= alu_d;
          depth_q    <= depth_q + D_ONE;
        end
        S_EXEC, S_REJECT: state_q <= S_IDLE;
        default:          state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rpn_stack_engine.sv
// tb_rpn_stack_engine: directed vectors with a queue scoreboard of expected RES_DAT values.
// Latency: a behavioural LIFO gives a top-of-stack read that lags each strobe by two cycles.
// Backpressure: each command waits for CMD_RDY within a bounded number of cycles.
module tb_rpn_stack_engine;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        CMD_STB = 1'b0;
  logic [3:0]  CMD_OP = 4'd0;
  logic [31:0] CMD_DAT = 32'd0;
  logic        CMD_RDY;
  logic        RES_STB;
  logic [31:0] RES_DAT;
  logic        ERR;
  logic [4:0]  DEPTH_O;
  logic        STK_PUSH_STB;
  logic [31:0] STK_PUSH_DAT;
  logic        STK_POP_STB;
  logic [31:0] STK_POP_DAT;
  logic        STK_POP_ACK;

  rpn_stack_engine #(.DEPTH(16), .DW(32)) dut (
    .CLK(CLK), .RST(RST),
    .CMD_STB(CMD_STB), .CMD_OP(CMD_OP), .CMD_DAT(CMD_DAT), .CMD_RDY(CMD_RDY),
    .RES_STB(RES_STB), .RES_DAT(RES_DAT), .ERR(ERR), .DEPTH_O(DEPTH_O),
    .STK_PUSH_STB(STK_PUSH_STB), .STK_PUSH_DAT(STK_PUSH_DAT),
    .STK_POP_STB(STK_POP_STB), .STK_POP_DAT(STK_POP_DAT), .STK_POP_ACK(STK_POP_ACK)
  );

  always #5 CLK = ~CLK;

  // Behavioural 16-entry LIFO: the pointer moves on the strobe edge, and the top is re-read one edge later
  logic [31:0] mem [16];
  logic [4:0]  sp;
  logic [31:0] pop_dat;
  always @(posedge CLK) begin
    if (!RST) begin
      sp      <= 5'd0;
      pop_dat <= 32'd0;
    end else begin
      pop_dat <= (sp != 5'd0) ? mem[4'(sp - 5'd1)] : 32'd0;
      if (STK_PUSH_STB && sp < 5'd16) begin
        mem[4'(sp)] <= STK_PUSH_DAT;
        sp          <= sp + 5'd1;
      end else if (STK_POP_STB && sp != 5'd0) begin
        sp <= sp - 5'd1;
      end
    end
  end
  assign STK_POP_DAT = pop_dat;
  assign STK_POP_ACK = (sp == 5'd0);

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int acc_cyc = 0;
  int last_res_cyc = 0;
  int res_cnt = 0;
  int stb_cnt = 0;
  logic both_seen = 1'b0;
  logic [31:0] exp_q [$];

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  // Monitor: compare every result pulse against the scoreboard and watch the strobes
  always @(negedge CLK) begin
    if (STK_PUSH_STB && STK_POP_STB) both_seen = 1'b1;
    if (STK_PUSH_STB || STK_POP_STB) stb_cnt++;
    if (RES_STB) begin
      res_cnt++;
      last_res_cyc = cyc;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL res_unexpected: got 0x%0h, expected no result", RES_DAT);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        if (RES_DAT !== e) begin
          errors++;
          $display("FAIL res_dat: got 0x%0h, expected 0x%0h", RES_DAT, e);
        end
      end
    end
  end

  task automatic wait_rdy(input string name);
    int n;
    n = 0;
    while (!CMD_RDY && n < 50) begin
      @(negedge CLK);
      n++;
    end
    if (!CMD_RDY) begin
      checks++;
      errors++;
      $display("FAIL %s: CMD_RDY still 0 after 50 cycles, expected 1", name);
    end
  endtask

  // Offer one command for a single cycle, then wait until the engine is idle again
  task automatic send(input logic [3:0] op, input logic [31:0] dat);
    @(negedge CLK);
    wait_rdy("rdy_before_cmd");
    CMD_STB = 1'b1;
    CMD_OP  = op;
    CMD_DAT = dat;
    acc_cyc = cyc;
    @(negedge CLK);
    CMD_STB = 1'b0;
    wait_rdy("rdy_after_cmd");
  endtask

  task automatic push_v(input logic [31:0] v);
    exp_q.push_back(v);
    send(4'd0, v);
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RST = 1'b0;
    repeat (3) @(negedge CLK);
    RST = 1'b1;
    exp_q.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int sb;
    int rb;
    logic [3:0] mid_op;

    // Reset state
    do_reset();
    @(negedge CLK);
    check("rst_cmd_rdy", 32'(CMD_RDY), 32'd1);
    check("rst_err", 32'(ERR), 32'd0);
    check("rst_res_dat", RES_DAT, 32'd0);
    check("rst_depth", 32'(DEPTH_O), 32'd0);
    check("rst_strobes", 32'({STK_PUSH_STB, STK_POP_STB, RES_STB}), 32'd0);

    // PUSH 5, PUSH 3, ADD
    push_v(32'd5);
    check("push_latency", 32'(last_res_cyc - acc_cyc), 32'd1);
    push_v(32'd3);
    exp_q.push_back(32'd8);
    send(4'd1, 32'd0);
    check("add_latency", 32'(last_res_cyc - acc_cyc), 32'd5);
    check("add_depth", 32'(DEPTH_O), 32'd1);
    check("add_held", RES_DAT, 32'd8);
    send(4'd7, 32'd0);
    check("drop_depth", 32'(DEPTH_O), 32'd0);

    // SUB wraps modulo 2^32
    push_v(32'h10);
    push_v(32'h30);
    exp_q.push_back(32'hFFFF_FFE0);
    send(4'd2, 32'd0);
    check("sub_err", 32'(ERR), 32'd0);
    check("sub_depth", 32'(DEPTH_O), 32'd1);
    send(4'd7, 32'd0);

    // ADD on an empty stack is rejected without any stack traffic
    sb = stb_cnt;
    rb = res_cnt;
    send(4'd1, 32'd0);
    check("uflow_strobes", 32'(stb_cnt - sb), 32'd0);
    check("uflow_res", 32'(res_cnt - rb), 32'd0);
    check("uflow_err", 32'(ERR), 32'd1);
    check("uflow_depth", 32'(DEPTH_O), 32'd0);
    push_v(32'd7);
    check("after_uflow_res", RES_DAT, 32'd7);
    check("err_sticky", 32'(ERR), 32'd1);
    send(4'd7, 32'd0);

    // Fill to 16, DUP overflows, DROP still works
    for (int i = 0; i < 16; i++) push_v(32'(100 + i));
    check("full_depth", 32'(DEPTH_O), 32'd16);
    sb = stb_cnt;
    rb = res_cnt;
    send(4'd6, 32'd0);
    check("oflow_strobes", 32'(stb_cnt - sb), 32'd0);
    check("oflow_res", 32'(res_cnt - rb), 32'd0);
    check("oflow_depth", 32'(DEPTH_O), 32'd16);
    send(4'd7, 32'd0);
    check("oflow_drop_depth", 32'(DEPTH_O), 32'd15);

    // Reset clears the sticky error and the depth
    do_reset();
    @(negedge CLK);
    check("rst2_err", 32'(ERR), 32'd0);
    check("rst2_depth", 32'(DEPTH_O), 32'd0);

    // PUSH 9, DUP, XOR
    push_v(32'd9);
    exp_q.push_back(32'd9);
    send(4'd6, 32'd0);
    check("dup_latency", 32'(last_res_cyc - acc_cyc), 32'd3);
    check("dup_depth", 32'(DEPTH_O), 32'd2);
    exp_q.push_back(32'd0);
    send(4'd5, 32'd0);
    check("xor_depth", 32'(DEPTH_O), 32'd1);
    send(4'd7, 32'd0);

    // Opcode 8
    push_v(32'd6);
    push_v(32'd7);
`ifdef RPN_MUL_EN
    exp_q.push_back(32'd42);
    send(4'd8, 32'd0);
    check("mul_latency", 32'(last_res_cyc - acc_cyc), 32'd5);
    check("mul_depth", 32'(DEPTH_O), 32'd1);
    check("mul_err", 32'(ERR), 32'd0);
    push_v(32'd7);
    mid_op = 4'd8;
`else
    rb = res_cnt;
    send(4'd8, 32'd0);
    check("op8_err", 32'(ERR), 32'd1);
    check("op8_depth", 32'(DEPTH_O), 32'd2);
    check("op8_res", 32'(res_cnt - rb), 32'd0);
    mid_op = 4'd1;
`endif

    // Reset at t3 of a binary op abandons it
    @(negedge CLK);
    wait_rdy("rdy_mid");
    CMD_STB = 1'b1;
    CMD_OP  = mid_op;
    CMD_DAT = 32'd0;
    @(negedge CLK);
    CMD_STB = 1'b0;
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    sb = stb_cnt;
    rb = res_cnt;
    @(negedge CLK);
    RST = 1'b1;
    repeat (10) @(negedge CLK);
    check("mid_rst_strobes", 32'(stb_cnt - sb), 32'd0);
    check("mid_rst_res", 32'(res_cnt - rb), 32'd0);
    check("mid_rst_rdy", 32'(CMD_RDY), 32'd1);
    check("mid_rst_depth", 32'(DEPTH_O), 32'd0);
    exp_q.delete();

    // Global properties
    check("pending_results", 32'(exp_q.size()), 32'd0);
    check("both_strobes", 32'(both_seen), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
